uart_receiver: RTL
==================

# uart_receiver

Receive side of the UART telemetry link. It oversamples the incoming serial line and decodes frames of 1 start bit, 8 data bits (LSB first), 1 even-parity bit and 1 stop bit. Each good byte is pushed into the RX FIFO through a single-cycle write strobe. It sits between the board's RX pin and the RX FIFO, and uses the same frame format and baud parameters as the transmit path.

## Interface
Parameters:
- clock_freq, 50_000_000, system clock frequency in Hz
- baud, 9600, line rate in bits/s; cycles_per_bit = clock_freq / baud (integer division), half_bit = cycles_per_bit / 2

Ports:
- clk  input  1  system clock, the only clock
- rst  input  1  reset, synchronous, active-high
- receive_wire  input  1  asynchronous UART RX line, idle HIGH
- fifo_full  input  1  RX FIFO cannot accept a write this cycle
- fifo_write  output  1  one-cycle pulse; data_out is valid in the same cycle
- data_out  output  8  last received byte; holds its value between writes
- parity_error  output  1  one-cycle pulse: parity mismatch, byte dropped
- framing_error  output  1  one-cycle pulse: stop bit sampled LOW, byte dropped
- overrun_error  output  1  one-cycle pulse: good byte dropped because fifo_full
- state_busy  output  1  HIGH whenever the FSM is not in IDLE

## Operation
- receive_wire passes through a 2-flop synchronizer (both flops reset to 1). A falling edge is detected as previous synchronized value 1 and current value 0.
- States: IDLE, START, DATA, PARITY, STOP. One bit_counter (0..cycles_per_bit-1) and a 3-bit bit_index.
- IDLE: bit_counter = 0, bit_index = 0. A falling edge moves the FSM to START.
- START: at bit_counter == half_bit-1, sample the line.
  - Sample 1: false start; go to IDLE with no error pulse.
  - Sample 0: clear bit_counter and go to DATA. From here on, every sample lands at mid-bit.
- DATA: at bit_counter == cycles_per_bit-1, shift the sample into shift_reg[bit_index] and increment bit_index. After the sample with bit_index == 7, go to PARITY.
- PARITY: at bit period end, latch the sample as rx_parity, then go to STOP.
- STOP: at bit period end, sample the stop bit and go to IDLE. Exit happens at mid-stop-bit, so the next start edge is never missed. Outcome is decided in priority order:
  - Stop bit 0: framing_error pulses. Parity is not checked.
  - rx_parity != ^shift_reg: parity_error pulses.
  - fifo_full: overrun_error pulses.
  - Otherwise: data_out <= shift_reg and fifo_write pulses.
- Exactly one of the four outcome pulses fires per completed frame. None fire on a false start.
- A low line that persists after a framing error (break) does not restart reception. IDLE needs a fresh 1→0 edge.

## Timing
- Reset values: fifo_write 0, data_out 8'h00, parity_error 0, framing_error 0, overrun_error 0, state_busy 0; synchronizer flops 1; FSM in IDLE.
- All outputs are registered. The outcome pulse is asserted in the cycle after the STOP sample clock edge and lasts exactly one cycle.
- Latency from the start edge at the synchronizer output to the outcome pulse: half_bit + 10·cycles_per_bit + 1 cycles. Synchronizer delay adds 2 cycles.
- fifo_full is sampled only in the STOP decision cycle. The FIFO-side handshake is write-and-forget: no back-pressure or retry.
- rst asserted mid-frame: on the next clock edge, return to IDLE, clear counters, and drop the partial byte. No pulses are issued. data_out keeps its reset value or is cleared to 0.
- The next frame may start on the cycle after the STOP exit; back-to-back frames with zero idle time are supported.

## Structure
- Shared package uart_pkg holds:
  - uart_state_t enum (IDLE, START, DATA, PARITY, STOP), shared with the transmitter
  - even_parity(byte) function
  - cycles_per_bit and half_bit derivation as a function of clock_freq and baud
- One sub-module: uart_rx_sync, containing the 2-flop synchronizer plus falling-edge detector, with outputs rx_sync and rx_fall.

## Test plan
Bench uses clock_freq=160, baud=10, giving cycles_per_bit=16 and half_bit=8.
- Send 0xA5 with parity 0 and stop 1 → one fifo_write pulse with data_out=0xA5; no error pulses; state_busy LOW after STOP.
- Send 0x07 with parity bit 0 (correct is 1) → parity_error pulse; no fifo_write; data_out unchanged.
- Send 0x3C with stop bit 0, then hold the line LOW for 40 cycles → exactly one framing_error pulse; the FSM stays in IDLE until the line goes HIGH and then falls.
- Drive the line LOW for 4 cycles, then HIGH → return to IDLE after the half-bit sample; no pulses.
- Send 0x81 with fifo_full=1 → overrun_error pulse; no fifo_write. Then send 0x55 back-to-back with fifo_full=0 → fifo_write with 0x55.
- Assert rst during bit 3 of a frame, deassert, then send 0xF0 → no pulse for the aborted frame; fifo_write with data_out=0xF0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame states, parity helper and baud timing derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction

  function automatic int calc_cycles_per_bit(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

  function automatic int calc_half_bit(input int clock_freq, input int baud);
    return calc_cycles_per_bit(clock_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop RX line synchronizer with falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset to the idle-high line level so reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rx_sync = r_sync;
  assign rx_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver feeding the RX FIFO with one-cycle strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clock_freq = 50_000_000,
  parameter int baud       = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       receive_wire,
  input  logic       fifo_full,
  output logic       fifo_write,
  output logic [7:0] data_out,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       state_busy
);

  localparam int CPB  = calc_cycles_per_bit(clock_freq, baud);
  localparam int HALF = calc_half_bit(clock_freq, baud);
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF - 1);

  uart_state_t r_state;
  uart_state_t w_state_next;

  logic [CW-1:0] r_bit_counter;
  logic [2:0]    r_bit_index;
  logic [7:0]    r_shift_reg;
  logic          r_rx_parity;
  logic          w_rx_sync;
  logic          w_rx_fall;
  logic          w_bit_tick;
  logic          w_half_tick;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (receive_wire),
    .rx_sync (w_rx_sync),
    .rx_fall (w_rx_fall)
  );

  assign w_bit_tick  = (r_bit_counter == LAST_CNT);
  assign w_half_tick = (r_bit_counter == HALF_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_rx_fall) w_state_next = START;
      START:   if (w_half_tick) w_state_next = w_rx_sync ? IDLE : DATA;
      DATA:    if (w_bit_tick && (r_bit_index == 3'd7)) w_state_next = PARITY;
      PARITY:  if (w_bit_tick) w_state_next = STOP;
      STOP:    if (w_bit_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_counter <= '0;
      r_bit_index   <= 3'd0;
      r_shift_reg   <= 8'h00;
      r_rx_parity   <= 1'b0;
      fifo_write    <= 1'b0;
      data_out      <= 8'h00;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      state_busy    <= 1'b0;
    end else begin
      fifo_write    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      state_busy    <= (w_state_next != IDLE);

      if (r_state == IDLE) begin
        r_bit_counter <= '0;
        r_bit_index   <= 3'd0;
      end else if ((r_state == START) ? w_half_tick : w_bit_tick) begin
        r_bit_counter <= '0;
      end else begin
        r_bit_counter <= r_bit_counter + 1'b1;
      end

      if (w_bit_tick) begin
        case (r_state)
          DATA: begin
            r_shift_reg[r_bit_index] <= w_rx_sync;
            r_bit_index              <= r_bit_index + 3'd1;
          end
          PARITY: r_rx_parity <= w_rx_sync;
          // Outcome priority: framing, then parity, then overrun.
          STOP: begin
            if (!w_rx_sync) begin
              framing_error <= 1'b1;
            end else if (r_rx_parity != even_parity(r_shift_reg)) begin
              parity_error <= 1'b1;
            end else if (fifo_full) begin
              overrun_error <= 1'b1;
            end else begin
              data_out   <= r_shift_reg;
              fifo_write <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
